fifo_pkt_reader: RTL

- Read-side counterpart of the flag_gen-based channel FIFO.
- Watches the FIFO level and only starts when a full packet is buffered. It then requests the formatter bus and, once granted, pops exactly pkt_len words back-to-back.
- Frames the output words with first/last markers.
- Sits between one channel FIFO and the MCDF arbiter/formatter.

---
 rtl/fifo_pkt_reader.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/fifo_pkt_reader.sv
// fifo_pkt_reader: read side of a channel FIFO. It waits until a full packet is
// buffered, requests the formatter bus, and on grant pops pkt_len words
// back-to-back, framing them with first/last markers.
//
// Ports:
//   clk, rst_n   clock (posedge) and asynchronous active-low reset
//   fifo_empty   FIFO empty flag (only used with RD_UNDERFLOW_CHK_EN)
//   fifo_level   words currently held in the FIFO
//   fifo_rdata   FIFO read data, valid one cycle after fifo_rd_en
//   fifo_rd_en   FIFO pop strobe
//   pkt_len      configured packet length, clamped to MAX_CNT
//   pkt_req      bus request to the arbiter
//   pkt_grant    single-cycle grant from the arbiter
//   pkt_valid    pkt_data qualifier
//   pkt_data     packet word (zero while pkt_valid is low)
//   pkt_first    first word of a packet
//   pkt_last     last word of a packet
//   busy         reader is not idle
//   rd_err       sticky underflow flag
//
// Optional build macro RD_UNDERFLOW_CHK_EN: when defined, an empty FIFO at the
// point a pop would be issued ends the packet early and sets rd_err. When
// undefined, fifo_empty is ignored and rd_err stays 0.

module fifo_pkt_reader #(
    parameter int unsigned DATA_WIDE = 32,
    parameter int unsigned PTR_WIDE  = 3,
    parameter int unsigned MAX_CNT   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [PTR_WIDE:0]     fifo_level,
    input  logic [DATA_WIDE-1:0]  fifo_rdata,
    output logic                  fifo_rd_en,
    input  logic [PTR_WIDE:0]     pkt_len,
    output logic                  pkt_req,
    input  logic                  pkt_grant,
    output logic                  pkt_valid,
    output logic [DATA_WIDE-1:0]  pkt_data,
    output logic                  pkt_first,
    output logic                  pkt_last,
    output logic                  busy,
    output logic                  rd_err
);

    localparam int unsigned LW = PTR_WIDE + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [LW-1:0]   len_q, len_d;
    logic [LW-1:0]   rd_cnt_q, rd_cnt_d;
    logic [LW-1:0]   len_eff;
    logic            req_q, req_d;
    logic            rd_en_q, rd_en_d;
    logic            valid_q, valid_d;
    logic            first_q, first_d;
    logic            last_q, last_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;
    logic            pad_q, pad_d;
    logic            empty_chk;

    // Underflow qualifier; constant 0 when the check is compiled out.
`ifdef RD_UNDERFLOW_CHK_EN
    assign empty_chk = fifo_empty;
`else
    logic unused_fifo_empty;
    assign empty_chk         = 1'b0;
    assign unused_fifo_empty = fifo_empty;
`endif

    // Packet length clamped to the FIFO depth.
    always_comb begin
        len_eff = (pkt_len > LW'(MAX_CNT)) ? LW'(MAX_CNT) : pkt_len;
    end

    // Next-state, counters and output-stage decode.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        rd_cnt_d = rd_cnt_q;
        rd_en_d  = 1'b0;
        err_d    = err_q;
        pad_d    = 1'b0;
        // The word popped this cycle appears on the packet port next cycle.
        valid_d  = rd_en_q;
        first_d  = rd_en_q && (rd_cnt_q == '0);
        last_d   = rd_en_q && (rd_cnt_q == len_q - LW'(1));

        unique case (state_q)
            IDLE: begin
                if ((len_eff != '0) && (fifo_level >= len_eff)) begin
                    state_d = REQ;
                    len_d   = len_eff;
                end
            end
            REQ: begin
                if (pkt_grant) begin
                    if (empty_chk) begin
                        // Nothing to pop: close with a single zero-data word.
                        state_d = DRAIN;
                        err_d   = 1'b1;
                        pad_d   = 1'b1;
                        valid_d = 1'b1;
                        first_d = 1'b1;
                        last_d  = 1'b1;
                    end else begin
                        state_d  = READ;
                        rd_cnt_d = '0;
                        rd_en_d  = 1'b1;
                    end
                end
            end
            READ: begin
                if (rd_cnt_q == len_q - LW'(1)) begin
                    state_d = DRAIN;
                end else if (empty_chk) begin
                    // Underflow: the word already in flight becomes the last.
                    state_d = DRAIN;
                    err_d   = 1'b1;
                    last_d  = rd_en_q;
                end else begin
                    rd_cnt_d = rd_cnt_q + LW'(1);
                    rd_en_d  = 1'b1;
                end
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_d  = (state_d == REQ);
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            len_q    <= '0;
            rd_cnt_q <= '0;
            req_q    <= 1'b0;
            rd_en_q  <= 1'b0;
            valid_q  <= 1'b0;
            first_q  <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            pad_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            rd_cnt_q <= rd_cnt_d;
            req_q    <= req_d;
            rd_en_q  <= rd_en_d;
            valid_q  <= valid_d;
            first_q  <= first_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            pad_q    <= pad_d;
        end
    end

    assign fifo_rd_en = rd_en_q;
    assign pkt_req    = req_q;
    assign pkt_valid  = valid_q;
    assign pkt_first  = first_q;
    assign pkt_last   = last_q;
    assign busy       = busy_q;
    assign rd_err     = err_q;
    // FIFO read data arrives one cycle after the pop, aligned with pkt_valid.
    assign pkt_data   = (valid_q && !pad_q) ? fifo_rdata : '0;

endmodule
